// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use hazard controller with a shadow tag pipeline (EX .. EX+FWD_DEPTH).
// Optional stall/forward statistics counters are enabled by defining FWD_HAZARD_STATS_EN.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hold,
  input  logic                       flush,
  input  logic                       id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]  id_rs,
  input  logic [NUM_SRC-1:0]         id_rs_used,
  input  logic [REG_AW-1:0]          id_rd,
  input  logic                       id_regwrite,
  input  logic                       id_memread,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic                       stall
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [15:0]                stall_cnt,
  output logic [15:0]                fwd_cnt
`endif
);

  localparam int unsigned CNT_W = 16;

  logic [FWD_DEPTH:0]              valid_q;
  logic [FWD_DEPTH:0]              regwrite_q;
  logic [FWD_DEPTH:0]              memread_q;
  logic [FWD_DEPTH:0][REG_AW-1:0]  rd_q;
  logic [NUM_SRC-1:0][REG_AW-1:0]  rs_q;
  logic [NUM_SRC-1:0]              rs_used_q;

  logic                            valid0_d;
  logic                            regwrite0_d;
  logic                            memread0_d;
  logic [REG_AW-1:0]               rd0_d;
  logic [NUM_SRC-1:0][REG_AW-1:0]  rs0_d;
  logic [NUM_SRC-1:0]              rs_used0_d;

  logic [FWD_DEPTH:0]              live_c;
  logic                            rs_hit_c;
  logic                            load_id_c;

  // A stage is a forwarding candidate only if it really writes a non-zero register
  always_comb begin
    live_c = '0;
    for (int unsigned s = 0; s <= FWD_DEPTH; s++) begin
      live_c[s] = valid_q[s] & regwrite_q[s] & (rd_q[s] != '0);
    end
  end

  // Load-use detection: ID consumer of the load currently sitting in EX
  always_comb begin
    rs_hit_c = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (id_rs_used[k] && (id_rs[k*REG_AW +: REG_AW] == rd_q[0])) begin
        rs_hit_c = 1'b1;
      end
    end
    stall = id_valid & ~flush & live_c[0] & memread_q[0] & rs_hit_c;
  end

  // Descending scan so the youngest matching producer overrides older ones
  always_comb begin
    fwd_sel = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (valid_q[0] && rs_used_q[k]) begin
        for (int unsigned s = FWD_DEPTH; s >= 1; s--) begin
          if (live_c[s] && (rd_q[s] == rs_q[k])) begin
            fwd_sel[k*SEL_W +: SEL_W] = SEL_W'(s);
          end
        end
      end
    end
  end

  // Stage 0 takes the ID instruction or a bubble; bubbles carry zeroed tags
  always_comb begin
    load_id_c   = id_valid & ~stall & ~flush;
    valid0_d    = load_id_c;
    regwrite0_d = 1'b0;
    memread0_d  = 1'b0;
    rd0_d       = '0;
    rs0_d       = '0;
    rs_used0_d  = '0;
    if (load_id_c) begin
      regwrite0_d = id_regwrite;
      memread0_d  = id_memread;
      rd0_d       = id_rd;
      rs0_d       = id_rs;
      rs_used0_d  = id_rs_used;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      regwrite_q <= '0;
      memread_q  <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      rs_used_q  <= '0;
    end else if (!hold) begin
      for (int unsigned s = 1; s <= FWD_DEPTH; s++) begin
        valid_q[s]    <= valid_q[s-1];
        regwrite_q[s] <= regwrite_q[s-1];
        memread_q[s]  <= memread_q[s-1];
        rd_q[s]       <= rd_q[s-1];
      end
      valid_q[0]    <= valid0_d;
      regwrite_q[0] <= regwrite0_d;
      memread_q[0]  <= memread0_d;
      rd_q[0]       <= rd0_d;
      rs_q          <= rs0_d;
      rs_used_q     <= rs_used0_d;
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

  // Saturating event counters, frozen while the pipeline is held
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (!hold) begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if ((fwd_sel != '0) && (fwd_cnt_q != '1)) begin
        fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule
